// File: rtl/instr_fifo_arbiter.sv
// Purpose: shares the prefetch byte FIFO read port among decode-side readers via round-robin ownership grants.
// Latency: grant one cycle after request; each byte is strobed to its popping client one cycle after the pop.
// Backpressure: pops stall while the FIFO is empty, during flush, or when the client is not the owner.
module instr_fifo_arbiter #(
  parameter int NUM_CLIENTS = 3,
  parameter int CNT_W       = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic [NUM_CLIENTS-1:0] req,
  output logic [NUM_CLIENTS-1:0] grant,
  input  logic [NUM_CLIENTS-1:0] client_rd_en,
  output logic [NUM_CLIENTS-1:0] client_empty,
  output logic [NUM_CLIENTS-1:0] client_valid,
  output logic [7:0]             rd_data,
  output logic [CNT_W-1:0]       pop_count,
  output logic                   proto_err,
  output logic                   fifo_rd_en,
  input  logic [7:0]             fifo_rd_data,
  input  logic                   fifo_empty
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CW    = IDX_W + 1;
  localparam logic [CW-1:0]    NUM_L  = CW'(NUM_CLIENTS);
  localparam logic [IDX_W-1:0] LAST_L = IDX_W'(NUM_CLIENTS - 1);

  typedef enum logic {IDLE, OWNED} state_e;

  state_e                 state_q;
  logic [NUM_CLIENTS-1:0] grant_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [CNT_W-1:0]       pop_count_q;
  logic                   popped_q;
  logic [IDX_W-1:0]       owner_q;
  logic                   proto_err_q;

  logic                   pick_vld_d;
  logic [IDX_W-1:0]       pick_d;
  logic [IDX_W-1:0]       rr_ptr_d;
  logic [NUM_CLIENTS-1:0] grant_d;
  logic [IDX_W-1:0]       own_idx;
  logic [CW-1:0]          cand;

  // Round-robin search: first requester at or after rr_ptr, wrapping modulo NUM_CLIENTS.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_d     = '0;
    cand       = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= NUM_L) cand = cand - NUM_L;
      if (!pick_vld_d && req[cand[IDX_W-1:0]]) begin
        pick_vld_d = 1'b1;
        pick_d     = cand[IDX_W-1:0];
      end
    end
    rr_ptr_d = (pick_d == LAST_L) ? '0 : pick_d + IDX_W'(1);
    grant_d  = '0;
    grant_d[pick_d] = 1'b1;
  end

  // Encode the one-hot grant so the pop can be tagged with its owner.
  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant_q[i]) own_idx = IDX_W'(i);
    end
  end

  // Pop only through the granted port; non-owner rd_en never reaches the FIFO.
  assign fifo_rd_en   = reset_n & ~fifo_empty & ~flush & (|(client_rd_en & grant_q));
  assign client_empty = ~grant_q | {NUM_CLIENTS{fifo_empty}};
  assign rd_data      = fifo_rd_data;
  assign grant        = grant_q;
  assign pop_count    = pop_count_q;
  assign proto_err    = proto_err_q;

  // Strobe follows the client that popped, even if its grant has since dropped.
  always_comb begin
    client_valid = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      client_valid[i] = popped_q & (owner_q == IDX_W'(i));
    end
  end

  // Ownership FSM with registered grant, round-robin pointer and per-grant pop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      pop_count_q <= '0;
    end else begin
      if (fifo_rd_en && (pop_count_q != {CNT_W{1'b1}})) begin
        pop_count_q <= pop_count_q + CNT_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (pick_vld_d && !flush) begin
            state_q     <= OWNED;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            pop_count_q <= '0;
          end
        end
        OWNED: begin
          // Flush and release share the same exit; rr_ptr is left alone either way.
          if (flush || !(|(req & grant_q))) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Pop tracking for the next-cycle strobe, plus the sticky protocol-error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      popped_q    <= 1'b0;
      owner_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      popped_q <= fifo_rd_en;
      if (fifo_rd_en) owner_q <= own_idx;
      proto_err_q <= proto_err_q | (|(client_rd_en & ~grant_q));
    end
  end

endmodule

// File: tb/tb_instr_fifo_arbiter.sv
// Bench for instr_fifo_arbiter: scripted scenarios with a byte scoreboard for the strobe path.
// Expected strobes are queued when a pop is driven and retired when client_valid appears.
// The FIFO is modelled as a queue with one-cycle read latency.
module tb_instr_fifo_arbiter;

  logic       clk;
  logic       reset_n;
  logic       flush;
  logic [2:0] req;
  logic [2:0] grant;
  logic [2:0] client_rd_en;
  logic [2:0] client_empty;
  logic [2:0] client_valid;
  logic [7:0] rd_data;
  logic [3:0] pop_count;
  logic       proto_err;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       fifo_empty;

  typedef struct {
    int         due;
    logic [2:0] vld;
    logic [7:0] dat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fq[$];
  int         cyc;
  int         n_cmp;
  int         n_bad;

  instr_fifo_arbiter #(.NUM_CLIENTS(3), .CNT_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .req          (req),
    .grant        (grant),
    .client_rd_en (client_rd_en),
    .client_empty (client_empty),
    .client_valid (client_valid),
    .rd_data      (rd_data),
    .pop_count    (pop_count),
    .proto_err    (proto_err),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: data appears one cycle after the pop.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
  end

  // Scoreboard: every strobe must match the oldest queued expectation, on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (client_valid !== 3'b000) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL strobe_unexpected: client_valid=%b rd_data=%h, required no strobe", client_valid, rd_data);
      end else begin
        e = sb.pop_front();
        if (client_valid !== e.vld || rd_data !== e.dat || cyc != e.due) begin
          n_bad++;
          $display("FAIL strobe: valid=%b data=%h cyc=%0d, required valid=%b data=%h cyc=%0d",
                   client_valid, rd_data, cyc, e.vld, e.dat, e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL strobe_missing: valid=000, required valid=%b data=%h at cyc=%0d", e.vld, e.dat, e.due);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic expect_pop(input logic [2:0] who, input logic [7:0] b);
    exp_t e;
    e.due = cyc + 1;
    e.vld = who;
    e.dat = b;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; req = '0; client_rd_en = '0; fifo_empty = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL rst_grant: got %b, required 000", grant); end
    n_cmp++; if (client_valid !== 3'b000) begin n_bad++; $display("FAIL rst_valid: got %b, required 000", client_valid); end
    n_cmp++; if (pop_count !== 4'd0) begin n_bad++; $display("FAIL rst_count: got %0d, required 0", pop_count); end
    n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL rst_proto: got %b, required 0", proto_err); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_rden: got %b, required 0", fifo_rd_en); end
    n_cmp++; if (client_empty !== 3'b111) begin n_bad++; $display("FAIL rst_empty: got %b, required 111", client_empty); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    push_byte(8'h12); push_byte(8'h34);
    tick(); req = 3'b001;
    @(negedge clk);
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL basic_grant_early: got %b, required 000", grant); end
    tick(); client_rd_en = 3'b001; expect_pop(3'b001, 8'h12);
    @(negedge clk);
    n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL basic_grant: got %b, required 001", grant); end
    n_cmp++; if (client_empty !== 3'b110) begin n_bad++; $display("FAIL basic_empty: got %b, required 110", client_empty); end
    n_cmp++; if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL basic_pop0: got %b, required 1", fifo_rd_en); end
    tick(); expect_pop(3'b001, 8'h34);
    @(negedge clk);
    n_cmp++; if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL basic_pop1: got %b, required 1", fifo_rd_en); end
    tick(); client_rd_en = 3'b000; req = 3'b000;
    @(negedge clk);
    n_cmp++; if (pop_count !== 4'd2) begin n_bad++; $display("FAIL basic_count: got %0d, required 2", pop_count); end
    n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL basic_hold: got %b, required 001", grant); end
    tick();
    @(negedge clk);
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL basic_release: got %b, required 000", grant); end
  endtask

  task automatic test_round_robin();
    logic [2:0] order [4];
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    do_reset();
    for (int k = 0; k < 4; k++) push_byte(8'hA0 + 8'(k));
    tick(); req = 3'b111;
    @(negedge clk);
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL rr_grant_early: got %b, required 000", grant); end
    for (int k = 0; k < 4; k++) begin
      tick();
      client_rd_en = order[k];
      expect_pop(order[k], 8'hA0 + 8'(k));
      req = req & ~order[k];
      if (k == 1) req = req | 3'b001;
      @(negedge clk);
      n_cmp++; if (grant !== order[k]) begin n_bad++; $display("FAIL rr_grant%0d: got %b, required %b", k, grant, order[k]); end
      n_cmp++; if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL rr_pop%0d: got %b, required 1", k, fifo_rd_en); end
      tick(); client_rd_en = 3'b000;
      @(negedge clk);
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL rr_gap%0d: got %b, required 000", k, grant); end
    end
  endtask

  task automatic test_proto_err();
    push_byte(8'hB0); push_byte(8'hB1);
    tick(); req = 3'b100;
    @(negedge clk);
    n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL pe_clean: got %b, required 0", proto_err); end
    tick(); client_rd_en = 3'b010;
    @(negedge clk);
    n_cmp++; if (grant !== 3'b100) begin n_bad++; $display("FAIL pe_grant: got %b, required 100", grant); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL pe_nopop: got %b, required 0", fifo_rd_en); end
    tick(); client_rd_en = 3'b100; expect_pop(3'b100, 8'hB0);
    @(negedge clk);
    n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL pe_set: got %b, required 1", proto_err); end
    n_cmp++; if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL pe_ownerpop: got %b, required 1", fifo_rd_en); end
    tick(); client_rd_en = 3'b110; expect_pop(3'b100, 8'hB1);
    @(negedge clk);
    n_cmp++; if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL pe_mixpop: got %b, required 1", fifo_rd_en); end
    tick(); client_rd_en = 3'b000; req = 3'b000;
    tick();
    @(negedge clk);
    n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL pe_sticky: got %b, required 1", proto_err); end
  endtask

  task automatic test_flush();
    push_byte(8'hC0); push_byte(8'hC1);
    tick(); req = 3'b001;
    tick(); client_rd_en = 3'b001; expect_pop(3'b001, 8'hC0);
    @(negedge clk);
    n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL fl_grant: got %b, required 001", grant); end
    n_cmp++; if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL fl_pop: got %b, required 1", fifo_rd_en); end
    tick(); flush = 1'b1;
    @(negedge clk);
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL fl_block: got %b, required 0", fifo_rd_en); end
    n_cmp++; if (client_valid !== 3'b001) begin n_bad++; $display("FAIL fl_strobe: got %b, required 001", client_valid); end
    tick(); flush = 1'b0; client_rd_en = 3'b000; req = 3'b111;
    @(negedge clk);
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL fl_drop: got %b, required 000", grant); end
    tick(); req = 3'b000;
    @(negedge clk);
    n_cmp++; if (grant !== 3'b010) begin n_bad++; $display("FAIL fl_rrptr: got %b, required 010", grant); end
    n_cmp++; if (pop_count !== 4'd0) begin n_bad++; $display("FAIL fl_count_clr: got %0d, required 0", pop_count); end
    tick();
    fq.delete();
    tick();
  endtask

  task automatic test_empty();
    tick(); req = 3'b010;
    tick(); client_rd_en = 3'b010;
    @(negedge clk);
    n_cmp++; if (grant !== 3'b010) begin n_bad++; $display("FAIL em_grant: got %b, required 010", grant); end
    n_cmp++; if (client_empty !== 3'b111) begin n_bad++; $display("FAIL em_view: got %b, required 111", client_empty); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL em_nopop: got %b, required 0", fifo_rd_en); end
    tick(); push_byte(8'hA5); expect_pop(3'b010, 8'hA5);
    @(negedge clk);
    n_cmp++; if (client_empty !== 3'b101) begin n_bad++; $display("FAIL em_view2: got %b, required 101", client_empty); end
    n_cmp++; if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL em_pop: got %b, required 1", fifo_rd_en); end
    tick(); client_rd_en = 3'b000; req = 3'b000;
    @(negedge clk);
    n_cmp++; if (pop_count !== 4'd1) begin n_bad++; $display("FAIL em_count: got %0d, required 1", pop_count); end
    tick(); tick();
  endtask

  task automatic test_saturate_reset();
    for (int i = 0; i < 22; i++) push_byte(8'h40 + 8'(i));
    tick(); req = 3'b001;
    for (int i = 0; i < 20; i++) begin
      tick(); client_rd_en = 3'b001; expect_pop(3'b001, 8'h40 + 8'(i));
      @(negedge clk);
      n_cmp++; if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL sat_pop%0d: got %b, required 1", i, fifo_rd_en); end
    end
    tick();
    n_cmp++; if (pop_count !== 4'd15) begin n_bad++; $display("FAIL sat_count: got %0d, required 15", pop_count); end
    #1;
    reset_n = 1'b0;
    sb.delete();
    #1;
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL arst_grant: got %b, required 000", grant); end
    n_cmp++; if (pop_count !== 4'd0) begin n_bad++; $display("FAIL arst_count: got %0d, required 0", pop_count); end
    n_cmp++; if (client_valid !== 3'b000) begin n_bad++; $display("FAIL arst_valid: got %b, required 000", client_valid); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL arst_rden: got %b, required 0", fifo_rd_en); end
    n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL arst_proto: got %b, required 0", proto_err); end
    tick(); client_rd_en = 3'b000; req = 3'b000;
    tick(); reset_n = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL post_rst_grant: got %b, required 000", grant); end
  endtask

  initial begin
    cyc = 0; n_cmp = 0; n_bad = 0;
    fifo_rd_data = 8'h00;
    test_reset();
    test_basic();
    test_round_robin();
    test_proto_err();
    test_flush();
    test_empty();
    test_saturate_reset();
    repeat (2) tick();
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_drain: got %0d pending strobes, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
